// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Brief    : Synchronizes and debounces a raw 1-bit input, with rise/fall
//            strobes. Optional glitch counter: DEBOUNCER_GLITCH_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module input_debouncer #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 8,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d,
  output logic       q,
  output logic       rise,
  output logic       fall
`ifdef DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int                 c_cnt_w    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [0:0]         c_stable   = 1'b0;
  localparam logic [0:0]         c_pending  = 1'b1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_d_sync;
  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [c_cnt_w-1:0]     w_cnt_nxt;
  logic                   w_commit;
  logic                   w_abort;
  logic                   w_q_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign w_d_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_stable;
      r_cnt   <= '0;
      q       <= RESET_LEVEL;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      q       <= w_q_nxt;
      rise    <= w_rise_nxt;
      fall    <= w_fall_nxt;
    end
  end

  // Any return of d_sync to the current level abandons the qualification.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      c_stable: begin
        if (w_d_sync != q) begin
          w_state_nxt = c_pending;
          w_cnt_nxt   = c_cnt_one;
        end
      end
      c_pending: begin
        if (w_d_sync == q) begin
          w_state_nxt = c_stable;
          w_abort     = 1'b1;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = c_stable;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = c_stable;
      end
    endcase
  end

  always_comb begin
    w_q_nxt    = w_commit ? w_d_sync : q;
    w_rise_nxt = w_commit &  w_d_sync;
    w_fall_nxt = w_commit & ~w_d_sync;
  end

`ifdef DEBOUNCER_GLITCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= 8'd0;
    end else if (w_abort && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_abort;
`endif

endmodule
`default_nettype wire
